// File: rtl/stream_word_loader_if.sv
// -----------------------------------------------------------------------------
// stream_word_loader_if
// Bundles the byte-stream input, control inputs and memory-write/status outputs
// of stream_word_loader.
//   master : drives load_en, byte_valid, byte_din, err_clr; observes the rest
//   slave  : the loader itself
// Signals:
//   load_en     loader enable
//   byte_valid  one-cycle strobe qualifying byte_din
//   byte_din    received byte
//   err_clr     clears the sticky error flag
//   wr_we       one-hot write strobe (NUM_CH bits)
//   wr_addr     byte address of the written word
//   wr_data     assembled little-endian word
//   run         core run enable
//   busy        loader is inside a frame or a run delay
//   done        one-cycle frame completion pulse
//   err         sticky error flag
// -----------------------------------------------------------------------------
interface stream_word_loader_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              load_en;
  logic              byte_valid;
  logic [7:0]        byte_din;
  logic              err_clr;
  logic [NUM_CH-1:0] wr_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              run;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output load_en, byte_valid, byte_din, err_clr,
    input  wr_we, wr_addr, wr_data, run, busy, done, err
  );

  modport slave (
    input  load_en, byte_valid, byte_din, err_clr,
    output wr_we, wr_addr, wr_data, run, busy, done, err
  );
endinterface

// File: rtl/stream_word_loader.sv
// -----------------------------------------------------------------------------
// stream_word_loader
// Framed byte-stream loader. Each frame is a header byte ([7]=cmd, [6:0]=channel),
// a little-endian length (words) and a little-endian base address, followed by
// len*BYTES payload bytes assembled LSB-first into DATA_W words. Each completed
// word is written to the selected channel at an auto-incrementing byte address.
// A header with cmd=1 starts a RUN_DELAY-cycle countdown after which run rises.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    stream_word_loader_if.slave (byte input, write port, status)
// Optional build macro:
//   LOADER_CKSUM_EN  each write frame with len>0 carries a trailing 8-bit
//                    modular sum of its payload bytes; a mismatch sets err and
//                    done pulses after the checksum byte instead of with the
//                    last write.
// -----------------------------------------------------------------------------
module stream_word_loader #(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int RUN_DELAY   = 100,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  stream_word_loader_if.slave  bus
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LEN_B  = LEN_W / 8;
  localparam int ADDR_B = ADDR_W / 8;
  localparam int DLY_W  = (RUN_DELAY > 0) ? $clog2(RUN_DELAY + 1) : 1;
  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_ADDR,
    S_DATA,
    S_RUN_WAIT,
    S_RUN
`ifdef LOADER_CKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  len_q;      // remaining words once DATA is entered
  logic [ADDR_W-1:0] addr_q;     // address of the next word to be written
  logic [DATA_W-1:0] word_q;
  logic [7:0]        bcnt_q;     // byte position inside the current field/word
  logic [6:0]        ch_q;
  logic              ch_ok_q;
  logic [DLY_W-1:0]  dly_q;
  logic [TO_W-1:0]   idle_q;
  logic [NUM_CH-1:0] wr_we_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              run_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
`ifdef LOADER_CKSUM_EN
  logic [7:0]        sum_q;
`endif

  // Fields fill from the top so that after N shifts the first byte sits at the LSB.
  logic [LEN_W-1:0]  len_shift_s;
  logic [ADDR_W-1:0] addr_shift_s;
  logic [DATA_W-1:0] word_shift_s;
  logic              ch_ok_s;
  logic              in_frame_s;
  logic              timeout_s;
  logic              hdr_bad_s;
  logic              cksum_bad_s;
  logic              err_set_s;

  assign len_shift_s  = (len_q  >> 8) | (LEN_W'(bus.byte_din)  << (LEN_W  - 8));
  assign addr_shift_s = (addr_q >> 8) | (ADDR_W'(bus.byte_din) << (ADDR_W - 8));
  assign word_shift_s = (word_q >> 8) | (DATA_W'(bus.byte_din) << (DATA_W - 8));
  assign ch_ok_s      = ({25'd0, bus.byte_din[6:0]} < 32'(NUM_CH));

`ifdef LOADER_CKSUM_EN
  assign in_frame_s  = (state_q == S_LEN) || (state_q == S_ADDR) ||
                       (state_q == S_DATA) || (state_q == S_CKSUM);
  assign cksum_bad_s = bus.load_en && bus.byte_valid && (state_q == S_CKSUM) &&
                       (bus.byte_din != sum_q);
`else
  assign in_frame_s  = (state_q == S_LEN) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign cksum_bad_s = 1'b0;
`endif

  // The idle counter holds the number of consecutive byte-free cycles already seen.
  assign timeout_s = bus.load_en && in_frame_s && !bus.byte_valid &&
                     (idle_q == TO_W'(TIMEOUT_CYC - 1));
  assign hdr_bad_s = bus.load_en && bus.byte_valid && !bus.byte_din[7] && !ch_ok_s &&
                     ((state_q == S_IDLE) || (state_q == S_RUN));
  assign err_set_s = hdr_bad_s || timeout_s || cksum_bad_s;

  // Frame parser, word assembler, run delay and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      word_q    <= '0;
      bcnt_q    <= 8'd0;
      ch_q      <= 7'd0;
      ch_ok_q   <= 1'b0;
      dly_q     <= '0;
      idle_q    <= '0;
      wr_we_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CKSUM_EN
      sum_q     <= 8'd0;
`endif
    end else begin
      wr_we_q <= '0;
      done_q  <= 1'b0;

      // A new error wins over a simultaneous clear.
      if (err_set_s) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end

      if (!bus.load_en) begin
        state_q <= S_IDLE;
        run_q   <= 1'b0;
        busy_q  <= 1'b0;
        bcnt_q  <= 8'd0;
        idle_q  <= '0;
      end else if (timeout_s) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        bcnt_q  <= 8'd0;
        idle_q  <= '0;
      end else begin
        if (in_frame_s) begin
          idle_q <= bus.byte_valid ? '0 : idle_q + TO_W'(1);
        end

        case (state_q)
          S_IDLE, S_RUN: begin
            if (bus.byte_valid) begin
              if (!bus.byte_din[7]) begin
                state_q <= S_LEN;
                run_q   <= 1'b0;
                busy_q  <= 1'b1;
                ch_q    <= bus.byte_din[6:0];
                ch_ok_q <= ch_ok_s;
                bcnt_q  <= 8'd0;
                idle_q  <= '0;
`ifdef LOADER_CKSUM_EN
                sum_q   <= 8'd0;
`endif
              end else if (state_q == S_IDLE) begin
                // Run command; a repeated run command while running is ignored.
                dly_q   <= DLY_W'(RUN_DELAY);
                state_q <= S_RUN_WAIT;
                busy_q  <= 1'b1;
              end
            end
          end

          S_LEN: begin
            if (bus.byte_valid) begin
              len_q <= len_shift_s;
              if (bcnt_q == 8'(LEN_B - 1)) begin
                bcnt_q  <= 8'd0;
                state_q <= S_ADDR;
              end else begin
                bcnt_q <= bcnt_q + 8'd1;
              end
            end
          end

          S_ADDR: begin
            if (bus.byte_valid) begin
              addr_q <= addr_shift_s;
              if (bcnt_q == 8'(ADDR_B - 1)) begin
                bcnt_q <= 8'd0;
                if (len_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                end else begin
                  state_q <= S_DATA;
                end
              end else begin
                bcnt_q <= bcnt_q + 8'd1;
              end
            end
          end

          S_DATA: begin
            if (bus.byte_valid) begin
              word_q <= word_shift_s;
`ifdef LOADER_CKSUM_EN
              sum_q  <= sum_q + bus.byte_din;
`endif
              if (bcnt_q == 8'(BYTES - 1)) begin
                bcnt_q    <= 8'd0;
                // An out-of-range channel is still parsed but never strobes.
                wr_we_q   <= ch_ok_q ? (NUM_CH'(1) << ch_q) : '0;
                wr_data_q <= word_shift_s;
                wr_addr_q <= addr_q;
                addr_q    <= addr_q + ADDR_W'(BYTES);
                len_q     <= len_q - LEN_W'(1);
                if (len_q == LEN_W'(1)) begin
`ifdef LOADER_CKSUM_EN
                  state_q <= S_CKSUM;
`else
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
`endif
                end
              end else begin
                bcnt_q <= bcnt_q + 8'd1;
              end
            end
          end

`ifdef LOADER_CKSUM_EN
          S_CKSUM: begin
            if (bus.byte_valid) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
`endif

          S_RUN_WAIT: begin
            // Bytes arriving during the countdown are dropped.
            if (dly_q == '0) begin
              run_q   <= 1'b1;
              state_q <= S_RUN;
              busy_q  <= 1'b0;
            end else begin
              dly_q <= dly_q - DLY_W'(1);
            end
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.wr_we   = wr_we_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.run     = run_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_stream_word_loader.sv
module tb_stream_word_loader;
  localparam int DW    = 32;
  localparam int NCH   = 2;
  localparam int AW    = 32;
  localparam int LW    = 16;
  localparam int RD    = 100;
  localparam int TO    = 40;
  localparam int BYTES = DW / 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_word_loader_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  stream_word_loader #(
    .DATA_W(DW), .NUM_CH(NCH), .ADDR_W(AW), .LEN_W(LW),
    .RUN_DELAY(RD), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic [NCH-1:0] we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0]     hdr;
    int             len;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  w0;
    logic [DW-1:0]  w1;
    logic [NCH-1:0] exp_we;
    logic [AW-1:0]  exp_addr;
    logic [DW-1:0]  exp_data;
    logic           exp_err;
  } vec_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_wr_cyc = -1;
  logic model_err = 1'b0;
  logic [DW-1:0] pay [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor of the write port and done pulses.
  always @(negedge clk) begin
    if (bus.wr_we != '0) begin
      obs_q.push_back({bus.wr_we, bus.wr_addr, bus.wr_data});
      last_wr_cyc = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; strobes one byte over the next posedge.
  task automatic put_byte(input logic [7:0] b, input int gap);
    bus.byte_valid = 1'b1;
    bus.byte_din   = b;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_wr_cyc = -1;
  endtask

  task automatic pulse_err_clr(input string tag);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    model_err = 1'b0;
    chk({tag, " err_clr"}, bus.err, 1'b0);
  endtask

  // Sends a write frame from pay[] and records the model's expected writes.
  task automatic send_frame(input logic [7:0] hdr, input int len, input logic [AW-1:0] addr,
                            input int gap, output logic [NCH-1:0] we_l,
                            output logic [AW-1:0] addr_l, output logic [DW-1:0] data_l,
                            output logic done_l);
    logic [7:0] fb[$];
    logic [7:0] sum;
    logic [NCH-1:0] oh;
    int lp;
    sum = 8'd0;
    lp = -1;
    we_l = '0;
    addr_l = '0;
    data_l = '0;
    done_l = 1'b0;
    fb.push_back(hdr);
    for (int i = 0; i < LW / 8; i++) fb.push_back(8'(len >> (8 * i)));
    for (int i = 0; i < AW / 8; i++) fb.push_back(8'(addr >> (8 * i)));
    for (int w = 0; w < len; w++) begin
      for (int b = 0; b < BYTES; b++) begin
        fb.push_back(pay[w][8*b +: 8]);
        sum = sum + pay[w][8*b +: 8];
      end
    end
    if (len > 0) lp = fb.size() - 1;
`ifdef LOADER_CKSUM_EN
    if (len > 0) fb.push_back(sum);
`endif
    if ({25'd0, hdr[6:0]} < NCH) begin
      oh = NCH'(1) << hdr[6:0];
      for (int i = 0; i < len; i++) exp_q.push_back({oh, addr + AW'(i * BYTES), pay[i]});
    end else begin
      model_err = 1'b1;
    end
    for (int i = 0; i < fb.size(); i++) begin
      put_byte(fb[i], ((i == lp) || (i == fb.size() - 1)) ? 0 : gap);
      if (i == lp) begin
        we_l = bus.wr_we;
        addr_l = bus.wr_addr;
        data_l = bus.wr_data;
      end
      if (i == fb.size() - 1) done_l = bus.done;
    end
  endtask

  task automatic settle_and_compare(input string tag);
    int n;
    repeat (3) @(negedge clk);
    chk({tag, " write count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, " write"}, obs_q[i], exp_q[i]);
    chk({tag, " done count"}, done_cnt, 1);
`ifndef LOADER_CKSUM_EN
    if (exp_q.size() > 0) chk({tag, " done with last write"}, done_cyc, last_wr_cyc);
`endif
    chk({tag, " err"}, bus.err, model_err);
    chk({tag, " busy"}, bus.busy, 1'b0);
    clear_obs();
  endtask

  initial begin
    vec_t vt[5];
    logic [NCH-1:0] we_l;
    logic [AW-1:0]  addr_l;
    logic [DW-1:0]  data_l;
    logic           done_l;
    int n;

    vt[0] = '{8'h00, 2, 32'h0,        32'hDEADBEEF, 32'h12345678, 2'b01, 32'h4,   32'h12345678, 1'b0};
    vt[1] = '{8'h01, 1, 32'h100,      32'h44332211, 32'h0,        2'b10, 32'h100, 32'h44332211, 1'b0};
    vt[2] = '{8'h05, 1, 32'h0,        32'hCAFEF00D, 32'h0,        2'b00, 32'h0,   32'h0,        1'b1};
    vt[3] = '{8'h00, 0, 32'h20,       32'h0,        32'h0,        2'b00, 32'h0,   32'h0,        1'b0};
    vt[4] = '{8'h01, 2, 32'hFFFFFFFC, 32'hA5A5A5A5, 32'h0F0F0F0F, 2'b10, 32'h0,   32'h0F0F0F0F, 1'b0};

    bus.load_en = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_din = 8'h00;
    bus.err_clr = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset wr_we", bus.wr_we, 2'b00);
    chk("reset wr_addr", bus.wr_addr, 32'h0);
    chk("reset wr_data", bus.wr_data, 32'h0);
    chk("reset run", bus.run, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
    chk("reset err", bus.err, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    clear_obs();

    // Directed table: back-to-back bytes, check the last write as it appears.
    for (int v = 0; v < 5; v++) begin
      pay[0] = vt[v].w0;
      pay[1] = vt[v].w1;
      send_frame(vt[v].hdr, vt[v].len, vt[v].addr, 0, we_l, addr_l, data_l, done_l);
      if (vt[v].len > 0) begin
        chk($sformatf("vec%0d last wr_we", v), we_l, vt[v].exp_we);
        if (vt[v].exp_we != '0) begin
          chk($sformatf("vec%0d last wr_addr", v), addr_l, vt[v].exp_addr);
          chk($sformatf("vec%0d last wr_data", v), data_l, vt[v].exp_data);
        end
      end
      chk($sformatf("vec%0d done at end", v), done_l, 1'b1);
      chk($sformatf("vec%0d err", v), bus.err, vt[v].exp_err);
      settle_and_compare($sformatf("vec%0d", v));
      if (vt[v].exp_err) pulse_err_clr($sformatf("vec%0d", v));
    end

    // Run command: exact delay, byte during countdown ignored, rerun ignored.
    put_byte(8'h80, 0);
    chk("run_wait busy", bus.busy, 1'b1);
    n = 0;
    while (!bus.run && n < 300) begin
      if (n == 10) begin
        bus.byte_valid = 1'b1;
        bus.byte_din = 8'h00;
      end else begin
        bus.byte_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.byte_valid = 1'b0;
    chk("run delay cycles", n, RD + 1);
    chk("run state busy", bus.busy, 1'b0);
    put_byte(8'h80, 3);
    chk("run ignores cmd1", bus.run, 1'b1);
    put_byte(8'h00, 0);
    chk("run drop on header", bus.run, 1'b0);
    chk("busy after header in run", bus.busy, 1'b1);
    for (int i = 0; i < 6; i++) put_byte(8'h00, 0);
    settle_and_compare("run then len0");

    // Timeout after two payload bytes.
    put_byte(8'h00, 0);
    put_byte(8'h01, 0);
    put_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) put_byte(8'h00, 0);
    put_byte(8'h11, 0);
    put_byte(8'h22, 0);
    repeat (TO - 2) @(negedge clk);
    chk("timeout not yet busy", bus.busy, 1'b1);
    repeat (3) @(negedge clk);
    chk("timeout busy", bus.busy, 1'b0);
    chk("timeout err", bus.err, 1'b1);
    chk("timeout writes", obs_q.size(), 0);
    chk("timeout done", done_cnt, 0);
    model_err = 1'b1;
    pulse_err_clr("timeout");
    clear_obs();
    pay[0] = 32'h0BADC0DE;
    send_frame(8'h00, 1, 32'h40, 1, we_l, addr_l, data_l, done_l);
    settle_and_compare("after timeout");

    // load_en low aborts a frame and ignores bytes; also drops run.
    put_byte(8'h01, 0);
    put_byte(8'h01, 0);
    put_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) put_byte(8'h00, 0);
    put_byte(8'h55, 0);
    bus.load_en = 1'b0;
    @(negedge clk);
    chk("load_en abort busy", bus.busy, 1'b0);
    for (int i = 0; i < 4; i++) put_byte(8'h66, 0);
    chk("load_en bytes ignored busy", bus.busy, 1'b0);
    bus.load_en = 1'b1;
    @(negedge clk);
    chk("load_en abort writes", obs_q.size(), 0);
    chk("load_en abort done", done_cnt, 0);
    put_byte(8'h80, 0);
    repeat (RD + 3) @(negedge clk);
    chk("run before load_en drop", bus.run, 1'b1);
    bus.load_en = 1'b0;
    @(negedge clk);
    chk("run after load_en drop", bus.run, 1'b0);
    bus.load_en = 1'b1;
    @(negedge clk);
    clear_obs();

`ifdef LOADER_CKSUM_EN
    // Checksum: a good frame via the builder, then a deliberately wrong sum.
    pay[0] = 32'h04030201;
    send_frame(8'h00, 1, 32'h0, 0, we_l, addr_l, data_l, done_l);
    settle_and_compare("cksum good");
    put_byte(8'h00, 0);
    put_byte(8'h01, 0);
    put_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) put_byte(8'h00, 0);
    for (int i = 1; i <= 4; i++) put_byte(8'(i), 0);
    put_byte(8'h0B, 0);
    chk("cksum bad done", bus.done, 1'b1);
    repeat (2) @(negedge clk);
    chk("cksum bad err", bus.err, 1'b1);
    chk("cksum bad write kept", obs_q.size(), 1);
    model_err = 1'b1;
    pulse_err_clr("cksum bad");
    clear_obs();
`endif

    // Randomized frames checked against the frame model.
    for (int f = 0; f < 25; f++) begin
      logic [7:0] hdr;
      int len;
      hdr = 8'($urandom_range(0, 2));
      len = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) pay[i] = $urandom;
      send_frame(hdr, len, $urandom, $urandom_range(0, 2), we_l, addr_l, data_l, done_l);
      settle_and_compare($sformatf("rand%0d", f));
      if ($urandom_range(0, 3) == 0) pulse_err_clr($sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
